// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the bus/datapath block (slave).
// The sequencer consumes the instruction word and halt request and drives every datapath strobe.
interface control_sequencer_if #(
    parameter int ALUCTL_W = 12
) ();
    logic [31:0]         IR;
    logic                stop;

    logic                PCout, PCin, IncPC, MARin, MDRin, MDRRead, MDRout, IRin;
    logic                Yin, Zin, Zlowout, Cout, BAout, Gra, Grb, Grc, Rin_in, Rout_in;
    logic                CONin, brIn, con_FF_Reset, RAMwrite, InPortout, OutPortIn;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                run;
    logic                illegal;
    logic [3:0]          tstep;

    modport master (
        input  IR, stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRRead, MDRout, IRin,
        output Yin, Zin, Zlowout, Cout, BAout, Gra, Grb, Grc, Rin_in, Rout_in,
        output CONin, brIn, con_FF_Reset, RAMwrite, InPortout, OutPortIn,
        output ALUControl, run, illegal, tstep
    );

    modport slave (
        output IR, stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRRead, MDRout, IRin,
        input  Yin, Zin, Zlowout, Cout, BAout, Gra, Grb, Grc, Rin_in, Rout_in,
        input  CONin, brIn, con_FF_Reset, RAMwrite, InPortout, OutPortIn,
        input  ALUControl, run, illegal, tstep
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: fetch T0-T2, opcode latched into T3, execute steps up to T7.
// All strobes are registered decodes of the next state and the latched opcode.
module control_sequencer #(
    parameter int ALUCTL_W = 12,
    parameter int ADD_BIT  = 0,
    parameter int SUB_BIT  = 1,
    parameter int AND_BIT  = 2,
    parameter int OR_BIT   = 3
) (
    input  logic                   clk,
    input  logic                   clr_n,
    control_sequencer_if.master    bus
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Step states are encoded as their step number so tstep falls straight out of the state.
    typedef enum logic [3:0] {
        S_T0    = 4'd0,
        S_T1    = 4'd1,
        S_T2    = 4'd2,
        S_T3    = 4'd3,
        S_T4    = 4'd4,
        S_T5    = 4'd5,
        S_T6    = 4'd6,
        S_T7    = 4'd7,
        S_RESET = 4'hE,
        S_HALT  = 4'hF
    } state_t;

    typedef struct packed {
        logic                pc_out;
        logic                pc_in;
        logic                inc_pc;
        logic                mar_in;
        logic                mdr_in;
        logic                mdr_read;
        logic                mdr_out;
        logic                ir_in;
        logic                y_in;
        logic                z_in;
        logic                zlow_out;
        logic                c_out;
        logic                ba_out;
        logic                gra;
        logic                grb;
        logic                grc;
        logic                rin;
        logic                rout;
        logic                con_in;
        logic                br_in;
        logic                con_ff_reset;
        logic                ram_write;
        logic                inport_out;
        logic                outport_in;
        logic [ALUCTL_W-1:0] alu;
        logic                run;
        logic                illegal;
        logic [3:0]          tstep;
    } ctl_t;

    localparam ctl_t CTL_RESET = ctl_t'({{($bits(ctl_t) - 4){1'b0}}, 4'hF});

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    ctl_t       ctl_q, ctl_d;

    logic unused_ir;
    assign unused_ir = ^bus.IR[26:0];

    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_step = S_T5;
            OP_LD, OP_ST, OP_BR:                            last_step = S_T7;
            default:                                        last_step = S_T3;
        endcase
    endfunction

    function automatic logic [ALUCTL_W-1:0] alu_sel(input logic [4:0] op);
        alu_sel = '0;
        case (op)
            OP_SUB:  alu_sel[SUB_BIT] = 1'b1;
            OP_AND:  alu_sel[AND_BIT] = 1'b1;
            OP_OR:   alu_sel[OR_BIT]  = 1'b1;
            default: alu_sel[ADD_BIT] = 1'b1;
        endcase
    endfunction

    function automatic ctl_t decode(input state_t s, input logic [4:0] op);
        ctl_t d;
        d = CTL_RESET;
        if (s != S_RESET && s != S_HALT) begin
            d.run   = 1'b1;
            d.tstep = s;
        end
        case (s)
            S_T0: begin d.pc_out = 1'b1; d.mar_in = 1'b1; d.inc_pc = 1'b1; d.z_in = 1'b1; end
            S_T1: begin d.zlow_out = 1'b1; d.pc_in = 1'b1; d.mdr_read = 1'b1; d.mdr_in = 1'b1; end
            S_T2: begin d.mdr_out = 1'b1; d.ir_in = 1'b1; end
            S_T3: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST: begin d.grb = 1'b1; d.ba_out = 1'b1; d.y_in = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                        begin d.grb = 1'b1; d.rout = 1'b1; d.y_in = 1'b1; end
                    OP_BR:  begin d.gra = 1'b1; d.rout = 1'b1; d.con_in = 1'b1; end
                    OP_JR:  begin d.gra = 1'b1; d.rout = 1'b1; d.pc_in = 1'b1; end
                    OP_IN:  begin d.inport_out = 1'b1; d.gra = 1'b1; d.rin = 1'b1; end
                    OP_OUT: begin d.gra = 1'b1; d.rout = 1'b1; d.outport_in = 1'b1; end
                    OP_NOP, OP_HALT: ;
                    default: d.illegal = 1'b1;
                endcase
            end
            S_T4: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        d.c_out = 1'b1; d.z_in = 1'b1; d.alu[ADD_BIT] = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        d.grc = 1'b1; d.rout = 1'b1; d.z_in = 1'b1; d.alu = alu_sel(op);
                    end
                    OP_BR:   begin d.pc_out = 1'b1; d.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                        begin d.zlow_out = 1'b1; d.gra = 1'b1; d.rin = 1'b1; end
                    OP_LD, OP_ST: begin d.zlow_out = 1'b1; d.mar_in = 1'b1; end
                    OP_BR: begin d.c_out = 1'b1; d.z_in = 1'b1; d.alu[ADD_BIT] = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD:   begin d.mdr_read = 1'b1; d.mdr_in = 1'b1; end
                    OP_ST:   begin d.gra = 1'b1; d.rout = 1'b1; d.mdr_in = 1'b1; end
                    OP_BR:   begin d.zlow_out = 1'b1; d.pc_in = 1'b1; d.br_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD:   begin d.mdr_out = 1'b1; d.gra = 1'b1; d.rin = 1'b1; end
                    OP_ST:   d.ram_write = 1'b1;
                    OP_BR:   d.con_ff_reset = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

    // stop is only consulted on the edge leaving an instruction's last step.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                state_d = S_T3;
                op_d    = bus.IR[31:27];
            end
            S_HALT:  state_d = S_HALT;
            default: begin
                if (state_q == last_step(op_q))
                    state_d = (op_q == OP_HALT || bus.stop) ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
        ctl_d = decode(state_d, op_d);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_RESET;
            op_q    <= '0;
            ctl_q   <= CTL_RESET;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.PCout        = ctl_q.pc_out;
    assign bus.PCin         = ctl_q.pc_in;
    assign bus.IncPC        = ctl_q.inc_pc;
    assign bus.MARin        = ctl_q.mar_in;
    assign bus.MDRin        = ctl_q.mdr_in;
    assign bus.MDRRead      = ctl_q.mdr_read;
    assign bus.MDRout       = ctl_q.mdr_out;
    assign bus.IRin         = ctl_q.ir_in;
    assign bus.Yin          = ctl_q.y_in;
    assign bus.Zin          = ctl_q.z_in;
    assign bus.Zlowout      = ctl_q.zlow_out;
    assign bus.Cout         = ctl_q.c_out;
    assign bus.BAout        = ctl_q.ba_out;
    assign bus.Gra          = ctl_q.gra;
    assign bus.Grb          = ctl_q.grb;
    assign bus.Grc          = ctl_q.grc;
    assign bus.Rin_in       = ctl_q.rin;
    assign bus.Rout_in      = ctl_q.rout;
    assign bus.CONin        = ctl_q.con_in;
    assign bus.brIn         = ctl_q.br_in;
    assign bus.con_FF_Reset = ctl_q.con_ff_reset;
    assign bus.RAMwrite     = ctl_q.ram_write;
    assign bus.InPortout    = ctl_q.inport_out;
    assign bus.OutPortIn    = ctl_q.outport_in;
    assign bus.ALUControl   = ctl_q.alu;
    assign bus.run          = ctl_q.run;
    assign bus.illegal      = ctl_q.illegal;
    assign bus.tstep        = ctl_q.tstep;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed step tables, hand-built corner sequences,
// and random instruction streams checked against a per-instruction microstep model.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if #(.ALUCTL_W(12)) bus ();
    control_sequencer #(.ALUCTL_W(12)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    localparam logic [23:0] PCO  = 24'h000001, PCI  = 24'h000002, INC  = 24'h000004;
    localparam logic [23:0] MARI = 24'h000008, MDRI = 24'h000010, MRD  = 24'h000020;
    localparam logic [23:0] MDRO = 24'h000040, IRI  = 24'h000080, YI   = 24'h000100;
    localparam logic [23:0] ZI   = 24'h000200, ZLO  = 24'h000400, CO   = 24'h000800;
    localparam logic [23:0] BAO  = 24'h001000, GRA  = 24'h002000, GRB  = 24'h004000;
    localparam logic [23:0] GRC  = 24'h008000, RIN  = 24'h010000, ROUT = 24'h020000;
    localparam logic [23:0] CONI = 24'h040000, BRI  = 24'h080000, CFR  = 24'h100000;
    localparam logic [23:0] RAMW = 24'h200000, INPO = 24'h400000, OUTP = 24'h800000;
    localparam logic [23:0] F0 = PCO | MARI | INC | ZI;
    localparam logic [23:0] F1 = ZLO | PCI | MRD | MDRI;
    localparam logic [23:0] F2 = MDRO | IRI;
    localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_AND = 12'h004, A_OR = 12'h008;

    logic [23:0] act_m;
    assign act_m = {bus.OutPortIn, bus.InPortout, bus.RAMwrite, bus.con_FF_Reset, bus.brIn,
                    bus.CONin, bus.Rout_in, bus.Rin_in, bus.Grc, bus.Grb, bus.Gra, bus.BAout,
                    bus.Cout, bus.Zlowout, bus.Zin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRRead,
                    bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout};

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] ref_m[8];
    logic [11:0] ref_a[8];
    int          ref_len;
    logic        ref_ill;
    logic        ref_halt;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  ts;
        logic [23:0] m;
        logic [11:0] a;
        logic        il;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(logic [31:0] ir, int ts, logic [23:0] m, logic [11:0] a, logic il);
        vec_t v;
        v.ir = ir; v.ts = 4'(ts); v.m = m; v.a = a; v.il = il;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [23:0] em, input logic [11:0] ea,
                       input logic eil, input logic erun, input logic [3:0] ets);
        logic [41:0] act, exp;
        act = {act_m, bus.ALUControl, bus.illegal, bus.run, bus.tstep};
        exp = {em, ea, eil, erun, ets};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got strobes=%h alu=%h ill=%b run=%b tstep=%h, expected strobes=%h alu=%h ill=%b run=%b tstep=%h",
                     nm, act_m, bus.ALUControl, bus.illegal, bus.run, bus.tstep, em, ea, eil, erun, ets);
        end
    endtask

    // At most one bus driver per cycle, checked on whatever the DUT actually drives.
    task automatic chk_bus(input string nm);
        int d;
        d = int'(bus.PCout) + int'(bus.Zlowout) + int'(bus.MDRout) + int'(bus.Cout)
          + int'(bus.BAout | bus.Rout_in) + int'(bus.InPortout);
        n_tests++;
        if (d > 1) begin
            n_fail++;
            $display("FAIL %s bus_drivers: got %0d drivers, expected at most 1", nm, d);
        end
    endtask

    // Microcode of one instruction, step by step, straight from the instruction descriptions.
    task automatic build_ref(input logic [4:0] op);
        for (int k = 0; k < 8; k++) begin ref_m[k] = '0; ref_a[k] = '0; end
        ref_m[0] = F0; ref_m[1] = F1; ref_m[2] = F2;
        ref_len = 4; ref_ill = 1'b0; ref_halt = 1'b0;
        case (op)
            5'b00001: begin ref_m[3] = GRB|BAO|YI; ref_m[4] = CO|ZI; ref_a[4] = A_ADD;
                            ref_m[5] = ZLO|GRA|RIN; ref_len = 6; end
            5'b00000: begin ref_m[3] = GRB|BAO|YI; ref_m[4] = CO|ZI; ref_a[4] = A_ADD;
                            ref_m[5] = ZLO|MARI; ref_m[6] = MRD|MDRI; ref_m[7] = MDRO|GRA|RIN;
                            ref_len = 8; end
            5'b00010: begin ref_m[3] = GRB|BAO|YI; ref_m[4] = CO|ZI; ref_a[4] = A_ADD;
                            ref_m[5] = ZLO|MARI; ref_m[6] = GRA|ROUT|MDRI; ref_m[7] = RAMW;
                            ref_len = 8; end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                ref_m[3] = GRB|ROUT|YI; ref_m[4] = GRC|ROUT|ZI; ref_m[5] = ZLO|GRA|RIN; ref_len = 6;
                ref_a[4] = (op == 5'b00011) ? A_ADD : (op == 5'b00100) ? A_SUB :
                           (op == 5'b00101) ? A_AND : A_OR;
            end
            5'b01100: begin ref_m[3] = GRB|ROUT|YI; ref_m[4] = CO|ZI; ref_a[4] = A_ADD;
                            ref_m[5] = ZLO|GRA|RIN; ref_len = 6; end
            5'b10010: begin ref_m[3] = GRA|ROUT|CONI; ref_m[4] = PCO|YI; ref_m[5] = CO|ZI;
                            ref_a[5] = A_ADD; ref_m[6] = ZLO|PCI|BRI; ref_m[7] = CFR; ref_len = 8; end
            5'b10100: ref_m[3] = GRA|ROUT|PCI;
            5'b10110: ref_m[3] = INPO|GRA|RIN;
            5'b10111: ref_m[3] = GRA|ROUT|OUTP;
            5'b11010: ;
            5'b11011: ref_halt = 1'b1;
            default:  ref_ill = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        bus.stop = 1'b0;
        bus.IR = '0;
        #1;
        chk("reset", '0, '0, 1'b0, 1'b0, 4'hF);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic step_chk(input string nm, input int i);
        @(posedge clk);
        #1;
        chk($sformatf("%s_t%0d", nm, i), ref_m[i], ref_a[i], (i == 3) && ref_ill, 1'b1, 4'(i));
        chk_bus(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  codes[13];
        logic [4:0]  op;
        logic [31:0] instr;
        logic        st;
        int          r;

        codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd20, 5'd22, 5'd23, 5'd26};
        bus.IR = '0;
        bus.stop = 1'b0;

        tbl.push_back(V(32'h09000000, 0, F0, 0, 0));
        tbl.push_back(V(32'h09000000, 1, F1, 0, 0));
        tbl.push_back(V(32'h09000000, 2, F2, 0, 0));
        tbl.push_back(V(32'h09000000, 3, GRB|BAO|YI, 0, 0));
        tbl.push_back(V(32'h09000000, 4, CO|ZI, A_ADD, 0));
        tbl.push_back(V(32'h09000000, 5, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(V(32'h18000000, 0, F0, 0, 0));
        tbl.push_back(V(32'h18000000, 1, F1, 0, 0));
        tbl.push_back(V(32'h18000000, 2, F2, 0, 0));
        tbl.push_back(V(32'h18000000, 3, GRB|ROUT|YI, 0, 0));
        tbl.push_back(V(32'h18000000, 4, GRC|ROUT|ZI, A_ADD, 0));
        tbl.push_back(V(32'h18000000, 5, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(V(32'h20000000, 0, F0, 0, 0));
        tbl.push_back(V(32'h20000000, 1, F1, 0, 0));
        tbl.push_back(V(32'h20000000, 2, F2, 0, 0));
        tbl.push_back(V(32'h20000000, 3, GRB|ROUT|YI, 0, 0));
        tbl.push_back(V(32'h20000000, 4, GRC|ROUT|ZI, A_SUB, 0));
        tbl.push_back(V(32'h20000000, 5, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(V(32'h90000023, 0, F0, 0, 0));
        tbl.push_back(V(32'h90000023, 1, F1, 0, 0));
        tbl.push_back(V(32'h90000023, 2, F2, 0, 0));
        tbl.push_back(V(32'h90000023, 3, GRA|ROUT|CONI, 0, 0));
        tbl.push_back(V(32'h90000023, 4, PCO|YI, 0, 0));
        tbl.push_back(V(32'h90000023, 5, CO|ZI, A_ADD, 0));
        tbl.push_back(V(32'h90000023, 6, ZLO|PCI|BRI, 0, 0));
        tbl.push_back(V(32'h90000023, 7, CFR, 0, 0));
        tbl.push_back(V(32'h10000000, 0, F0, 0, 0));
        tbl.push_back(V(32'h10000000, 1, F1, 0, 0));
        tbl.push_back(V(32'h10000000, 2, F2, 0, 0));
        tbl.push_back(V(32'h10000000, 3, GRB|BAO|YI, 0, 0));
        tbl.push_back(V(32'h10000000, 4, CO|ZI, A_ADD, 0));
        tbl.push_back(V(32'h10000000, 5, ZLO|MARI, 0, 0));
        tbl.push_back(V(32'h10000000, 6, GRA|ROUT|MDRI, 0, 0));
        tbl.push_back(V(32'h10000000, 7, RAMW, 0, 0));
        tbl.push_back(V(32'hF8000000, 0, F0, 0, 0));
        tbl.push_back(V(32'hF8000000, 1, F1, 0, 0));
        tbl.push_back(V(32'hF8000000, 2, F2, 0, 0));
        tbl.push_back(V(32'hF8000000, 3, '0, 0, 1));
        tbl.push_back(V(32'h09000000, 0, F0, 0, 0));

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            bus.IR = tbl[k].ir;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", k), tbl[k].m, tbl[k].a, tbl[k].il, 1'b1, tbl[k].ts);
            chk_bus("vec");
        end
        $display("[TB] directed table: %0d rows applied", tbl.size());

        // halt opcode: run drops after T3 and the state is held.
        do_reset();
        bus.IR = 32'hD8000000;
        build_ref(5'b11011);
        for (int i = 0; i < 4; i++) step_chk("halt", i);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("halt_hold%0d", c), '0, '0, 1'b0, 1'b0, 4'hF);
        end
        $display("[TB] halt opcode sequence");

        // ld interrupted by clr_n in the middle of T5.
        do_reset();
        bus.IR = 32'h00000000;
        build_ref(5'b00000);
        for (int i = 0; i < 6; i++) step_chk("ld", i);
        #2;
        clr_n = 1'b0;
        #1;
        chk("async_clr", '0, '0, 1'b0, 1'b0, 4'hF);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_t0", F0, '0, 1'b0, 1'b1, 4'd0);
        $display("[TB] ld with clr_n mid-T5");

        // stop raised early in add: instruction completes, then halts.
        do_reset();
        bus.IR = 32'h18000000;
        build_ref(5'b00011);
        for (int i = 0; i < 6; i++) begin
            bus.stop = (i >= 1);
            step_chk("add_stop", i);
        end
        @(posedge clk);
        #1;
        chk("stop_halt", '0, '0, 1'b0, 1'b0, 4'hF);
        $display("[TB] add with stop held");

        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      op = 5'($urandom);
            else if (r == 1) op = 5'b11011;
            else             op = codes[$urandom_range(0, 12)];
            instr = {op, 27'($urandom)};
            build_ref(op);
            for (int i = 0; i < ref_len; i++) begin
                bus.IR = (i == 3) ? instr : $urandom;
                if (i > 0) bus.stop = ($urandom_range(0, 3) == 0);
                step_chk($sformatf("rnd%0d", n), i);
            end
            st = ($urandom_range(0, 9) == 0);
            bus.stop = st;
            bus.IR = $urandom;
            $display("[TB] instr %0d op=%b steps=%0d halt=%0d", n, op, ref_len, st || ref_halt);
            if (st || ref_halt) begin
                @(posedge clk);
                #1;
                chk($sformatf("rnd%0d_halt", n), '0, '0, 1'b0, 1'b0, 4'hF);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
